// File: rtl/cla_pkg.sv
// Shared types and geometry for the cacheline-to-burst adapter.
// The beat-order selection is controlled by CLA_CRIT_WORD_FIRST_EN in cacheline_burst_adapter.
package cla_pkg;

  localparam int LINE_W     = 256;
  localparam int BURST_W    = 64;
  localparam int ADDR_W     = 32;
  localparam int BEATS      = LINE_W / BURST_W;
  localparam int BEAT_IDX_W = $clog2(BEATS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } cla_state_e;

  // Bit offset of beat idx within a cacheline.
  function automatic int beat_slice(input logic [BEAT_IDX_W-1:0] idx);
    return int'(idx) * BURST_W;
  endfunction

endpackage

// File: rtl/cacheline_burst_adapter.sv
// Converts one 256-bit line read/write into a 4-beat 64-bit memory burst.
// Define CLA_CRIT_WORD_FIRST_EN to start the burst at the requested word (address_i[4:3]).
//
// state | meaning
// IDLE  | waiting for read_i/write_i; latch address, line and start beat on accept
// RD    | read burst, read_o high, each resp_i stores burst_i into the current beat
// WR    | write burst, write_o high, burst_o shows the current beat
// DONE  | one-cycle resp_o; line_o holds the last completed read line
module cacheline_burst_adapter
  import cla_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [LINE_W-1:0]  line_i,
  output logic [LINE_W-1:0]  line_o,
  input  logic [ADDR_W-1:0]  address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  input  logic [BURST_W-1:0] burst_i,
  output logic [BURST_W-1:0] burst_o,
  output logic [ADDR_W-1:0]  address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

`ifdef CLA_CRIT_WORD_FIRST_EN
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(32'h7);
`else
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(32'h1F);
`endif

  cla_state_e            r_state;
  cla_state_e            w_state_nxt;
  logic [ADDR_W-1:0]     r_addr;
  logic [LINE_W-1:0]     r_buf;
  logic [LINE_W-1:0]     r_line_o;
  logic [BEAT_IDX_W-1:0] r_cnt;
  logic [BEAT_IDX_W-1:0] r_left;
  logic [BEAT_IDX_W-1:0] w_start;
  logic [LINE_W-1:0]     w_rd_line;
  logic                  w_last;

`ifdef CLA_CRIT_WORD_FIRST_EN
  assign w_start = address_i[4:3];
`else
  assign w_start = '0;
`endif

  // r_left counts down the beats still owed; the burst ends on resp_i at zero.
  assign w_last = resp_i && (r_left == '0);

  always_comb begin
    w_rd_line = r_buf;
    w_rd_line[beat_slice(r_cnt) +: BURST_W] = burst_i;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (write_i)     w_state_nxt = WR;
        else if (read_i) w_state_nxt = RD;
      end
      RD:      if (w_last) w_state_nxt = DONE;
      WR:      if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    read_o    = 1'b0;
    write_o   = 1'b0;
    resp_o    = 1'b0;
    burst_o   = '0;
    address_o = '0;
    case (r_state)
      RD: begin
        read_o    = 1'b1;
        address_o = r_addr & ADDR_MASK;
      end
      WR: begin
        write_o   = 1'b1;
        address_o = r_addr & ADDR_MASK;
        burst_o   = r_buf[beat_slice(r_cnt) +: BURST_W];
      end
      DONE:    resp_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr   <= '0;
      r_buf    <= '0;
      r_line_o <= '0;
      r_cnt    <= '0;
      r_left   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (read_i || write_i) begin
            r_addr <= address_i;
            r_buf  <= line_i;
            r_cnt  <= w_start;
            r_left <= BEAT_IDX_W'(BEATS - 1);
          end
        end
        RD: begin
          if (resp_i) begin
            r_buf  <= w_rd_line;
            r_cnt  <= r_cnt + BEAT_IDX_W'(1);
            r_left <= r_left - BEAT_IDX_W'(1);
            if (w_last) r_line_o <= w_rd_line;
          end
        end
        WR: begin
          if (resp_i) begin
            r_cnt  <= r_cnt + BEAT_IDX_W'(1);
            r_left <= r_left - BEAT_IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign line_o = r_line_o;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Randomized scoreboard bench for cacheline_burst_adapter (either CLA_CRIT_WORD_FIRST_EN build).
module tb_cacheline_burst_adapter;

`ifdef CLA_CRIT_WORD_FIRST_EN
  localparam bit CRIT = 1'b1;
`else
  localparam bit CRIT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [255:0] line_i, line_o;
  logic [31:0]  address_i, address_o;
  logic         read_i, write_i, resp_o;
  logic [63:0]  burst_i, burst_o;
  logic         read_o, write_o, resp_i;

  cacheline_burst_adapter dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [63:0] data;
  } beat_t;

  beat_t        exp_beat_q[$];
  logic [255:0] exp_line_q[$];
  int           gap_q[$];
  logic [63:0]  rd_q[$];

  int           checks = 0;
  int           errors = 0;
  int           beats_seen = 0;
  int           resp_seen = 0;
  int           txn_done = 0;
  bit           tie_high = 1'b0;
  logic [255:0] last_rd_line = '0;

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [255:0] rand_line();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic logic [31:0] exp_addr_o(input logic [31:0] a);
    return CRIT ? (a & ~32'h7) : (a & ~32'h1F);
  endfunction

  // Monitor: pops expectations whenever the DUT presents a beat or a completion.
  always @(negedge clk) begin
    if (!rst) begin
      if (read_o || write_o) begin
        check("strobe_exclusive", {255'b0, read_o && write_o}, 256'b0);
        if (exp_beat_q.size() > 0) check("address_o_stable", {224'b0, address_o}, {224'b0, exp_beat_q[0].addr});
      end
      if ((read_o || write_o) && resp_i) begin
        if (exp_beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got beat with no pending transaction, required none");
        end else begin
          beat_t b;
          b = exp_beat_q.pop_front();
          check("beat_write_o", {255'b0, write_o}, {255'b0, b.wr});
          check("beat_read_o",  {255'b0, read_o},  {255'b0, !b.wr});
          if (b.wr) check("burst_o", {192'b0, burst_o}, {192'b0, b.data});
        end
        beats_seen++;
      end
      if (resp_o) begin
        resp_seen++;
        check("strobes_in_done", {254'b0, read_o, write_o}, 256'b0);
        if (exp_line_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp_o: got resp_o=1 required 0");
        end else begin
          check("line_o", line_o, exp_line_q.pop_front());
        end
      end
    end
  end

  // Memory model: per beat waits the queued gap, then acknowledges and supplies read data.
  initial begin
    resp_i  = 1'b0;
    burst_i = '0;
    forever begin
      @(posedge clk); #1;
      resp_i = tie_high;
      if (read_o || write_o) begin
        int gap;
        gap = (gap_q.size() > 0) ? gap_q.pop_front() : 0;
        for (int g = 0; g < gap && (read_o || write_o); g++) begin
          resp_i = 1'b0;
          @(posedge clk); #1;
        end
        if (read_o || write_o) begin
          resp_i = 1'b1;
          if (read_o) burst_i = (rd_q.size() > 0) ? rd_q.pop_front() : 64'hDEAD_BEEF_DEAD_BEEF;
        end
      end
    end
  end

  // Expects to be called at posedge+#1; returns at posedge+#1 with the request dropped.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [255:0] line, input int gaps[4], input logic [63:0] rdata[4]);
    int           start, k, n, exp_lat;
    logic [255:0] rline;
    start   = CRIT ? int'(addr[4:3]) : 0;
    rline   = '0;
    exp_lat = 6;
    for (int j = 0; j < 4; j++) begin
      int g;
      g = tie_high ? 0 : gaps[j];
      k = (start + j) % 4;
      gap_q.push_back(g);
      exp_lat += g;
      exp_beat_q.push_back('{wr, exp_addr_o(addr), line[k*64 +: 64]});
      if (!wr) begin
        rd_q.push_back(rdata[j]);
        rline[k*64 +: 64] = rdata[j];
      end
    end
    if (!wr) last_rd_line = rline;
    exp_line_q.push_back(last_rd_line);
    read_i = rd; write_i = wr; address_i = addr; line_i = line;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        address_i = $urandom();
        line_i    = rand_line();
      end
    end while (!resp_o && n < 200);
    if (!resp_o) begin
      checks++; errors++;
      $display("FAIL resp_timeout: got no resp_o after %0d cycles, required one", n);
    end else begin
      check("latency", 256'(n), 256'(exp_lat));
    end
    txn_done++;
    @(posedge clk); #1;
    read_i = 1'b0; write_i = 1'b0;
  endtask

  initial begin
    int           gz[4], gr[4], g1[4];
    logic [63:0]  rd4[4];
    logic [255:0] pat;
    int           base, n;
    gz = '{0, 0, 0, 0};
    gr = '{0, 2, 0, 1};
    g1 = '{1, 1, 1, 1};
    rst = 1'b1; read_i = 0; write_i = 0; address_i = '0; line_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_read_o",    {255'b0, read_o},  256'b0);
    check("rst_write_o",   {255'b0, write_o}, 256'b0);
    check("rst_resp_o",    {255'b0, resp_o},  256'b0);
    check("rst_burst_o",   {192'b0, burst_o}, 256'b0);
    check("rst_address_o", {224'b0, address_o}, 256'b0);
    check("rst_line_o",    line_o, 256'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Write, memory ack tied high
    tie_high = 1'b1;
    pat = {64'h3333_3333_3333_3333, 64'h2222_2222_2222_2222,
           64'h1111_1111_1111_1111, 64'h0A0A_0A0A_0A0A_0A0A};
    rd4 = '{64'h0, 64'h0, 64'h0, 64'h0};
    run_txn(1'b0, 1'b1, 32'h0000_1040, pat, gz, rd4);
    tie_high = 1'b0;

    // Read with uneven ack gaps
    rd4 = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    run_txn(1'b1, 1'b0, 32'h0000_1040, rand_line(), gr, rd4);

    // Both requests: write wins
    run_txn(1'b1, 1'b1, 32'h0000_3000, rand_line(), gr, rd4);

    // Reset after the second beat of a read
    base = beats_seen;
    for (int j = 0; j < 4; j++) begin
      gap_q.push_back(1);
      rd_q.push_back({$urandom(), $urandom()});
      exp_beat_q.push_back('{1'b0, exp_addr_o(32'h0000_4000), 64'h0});
    end
    read_i = 1'b1; address_i = 32'h0000_4000;
    n = 0;
    while (beats_seen < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (beats_seen < base + 2) begin
      checks++; errors++;
      $display("FAIL reset_test_beats: got %0d beats required 2", beats_seen - base);
    end
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0; read_i = 1'b0;
    gap_q.delete(); rd_q.delete(); exp_beat_q.delete(); exp_line_q.delete();
    last_rd_line = '0;
    @(negedge clk);
    check("abort_read_o",  {255'b0, read_o},  256'b0);
    check("abort_write_o", {255'b0, write_o}, 256'b0);
    check("abort_resp_o",  {255'b0, resp_o},  256'b0);
    check("abort_line_o",  line_o, 256'b0);
    repeat (3) @(posedge clk);
    #1;
    rd4 = '{64'hB0B0, 64'hB1B1, 64'hB2B2, 64'hB3B3};
    run_txn(1'b1, 1'b0, 32'h0000_4000, rand_line(), g1, rd4);

    // Critical-word address
    rd4 = '{64'hC0FFEE_0001, 64'hC0FFEE_0002, 64'hC0FFEE_0003, 64'hC0FFEE_0004};
    run_txn(1'b1, 1'b0, 32'h0000_2050, rand_line(), gz, rd4);

    // Back-to-back write then read
    run_txn(1'b0, 1'b1, 32'h0000_5018, rand_line(), gz, rd4);
    rd4 = '{64'h1, 64'h2, 64'h3, 64'h4};
    run_txn(1'b1, 1'b0, 32'h0000_5018, rand_line(), gz, rd4);

    // Randomized traffic
    for (int t = 0; t < 40; t++) begin
      int          kind;
      int          gg[4];
      logic [63:0] dd[4];
      kind = $urandom_range(0, 4);
      tie_high = ($urandom_range(0, 3) == 0);
      for (int j = 0; j < 4; j++) begin
        gg[j] = $urandom_range(0, 3);
        dd[j] = {$urandom(), $urandom()};
      end
      run_txn(kind != 1, kind != 0 && kind < 3 ? 1'b1 : (kind == 1), $urandom(), rand_line(), gg, dd);
      tie_high = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    check("resp_count", 256'(resp_seen), 256'(txn_done));
    check("beats_left", 256'(exp_beat_q.size()), 256'b0);
    check("lines_left", 256'(exp_line_q.size()), 256'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running required completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

endmodule
